// File: rtl/hash_chain_driver.sv
// Drives a chained hash core one message word at a time. Each word's request carries
// the previous digest as its chaining value. A digest record is presented when the message ends.
module hash_chain_driver #(
    parameter logic [31:0] IV      = 32'h6A09_E667,
    parameter int          TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_key,
    input  logic [31:0] exp_hash,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic [31:0] core_key,
    output logic        core_in_valid,
    output logic [31:0] core_in_data,
    output logic [31:0] core_in_prev,
    input  logic        core_busy,
    input  logic        core_out_valid,
    input  logic [31:0] core_out_hash,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_hash,
    output logic        d_match,
    output logic [15:0] d_len,
    output logic        d_err
);

    localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        WAIT,
        FLUSH,
        DONE
    } state_t;

    state_t             state_reg;
    logic [31:0]        key_reg;
    logic [31:0]        exp_reg;
    logic [31:0]        chain_reg;
    logic [31:0]        word_reg;
    logic               last_reg;
    logic               civ_reg;
    logic               dvalid_reg;
    logic [31:0]        hash_reg;
    logic               match_reg;
    logic               err_reg;
    logic [15:0]        len_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;

    logic               take;
    logic               timeout_hit;

    // Ready is gated by rst_n so the stream sees no acceptance while reset is held.
    assign s_ready = rst_n & ((((state_reg == IDLE) || (state_reg == ACCEPT)) & ~core_busy)
                              | (state_reg == FLUSH));
    assign take        = s_valid & s_ready;
    assign timeout_hit = (wait_cnt_reg == CNT_LAST);

    assign core_key      = key_reg;
    assign core_in_valid = civ_reg;
    assign core_in_data  = word_reg;
    assign core_in_prev  = chain_reg;

    assign d_valid = dvalid_reg;
    assign d_hash  = hash_reg;
    assign d_match = match_reg;
    assign d_len   = len_reg;
    assign d_err   = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            key_reg      <= '0;
            exp_reg      <= '0;
            chain_reg    <= IV;
            word_reg     <= '0;
            last_reg     <= 1'b0;
            civ_reg      <= 1'b0;
            dvalid_reg   <= 1'b0;
            hash_reg     <= '0;
            match_reg    <= 1'b0;
            err_reg      <= 1'b0;
            len_reg      <= '0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        key_reg   <= cfg_key;
                        exp_reg   <= exp_hash;
                        chain_reg <= IV;
                        len_reg   <= 16'd1;
                        word_reg  <= s_data;
                        last_reg  <= s_last;
                        civ_reg   <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end

                ACCEPT: begin
                    if (take) begin
                        word_reg  <= s_data;
                        last_reg  <= s_last;
                        len_reg   <= (len_reg == 16'hFFFF) ? len_reg : len_reg + 16'd1;
                        civ_reg   <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end

                ISSUE: begin
                    civ_reg      <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= WAIT;
                end

                WAIT: begin
                    // A response arriving on the last counted cycle still wins over the timeout.
                    if (core_out_valid) begin
                        chain_reg <= core_out_hash;
                        if (last_reg) begin
                            hash_reg   <= core_out_hash;
                            match_reg  <= (core_out_hash == exp_reg);
                            dvalid_reg <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            state_reg  <= ACCEPT;
                        end
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                        if (last_reg) begin
                            hash_reg   <= '0;
                            match_reg  <= 1'b0;
                            dvalid_reg <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            state_reg  <= FLUSH;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                FLUSH: begin
                    // Only an aborted message reaches here, so the digest is always the error form.
                    if (take && s_last) begin
                        hash_reg   <= '0;
                        match_reg  <= 1'b0;
                        dvalid_reg <= 1'b1;
                        state_reg  <= DONE;
                    end
                end

                DONE: begin
                    if (d_ready) begin
                        dvalid_reg <= 1'b0;
                        err_reg    <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    civ_reg    <= 1'b0;
                    dvalid_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_chain_driver.sv
// Bench for hash_chain_driver: a behavioural hash core with fixed response latency,
// directed scenarios plus randomized messages checked against a chained-digest model.
module tb_hash_chain_driver;

    localparam logic [31:0] IV = 32'h6A09_E667;
    localparam int          TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_key;
    logic [31:0] exp_hash;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [31:0] core_key;
    logic        core_in_valid;
    logic [31:0] core_in_data;
    logic [31:0] core_in_prev;
    logic        core_busy;
    logic        core_out_valid = 1'b0;
    logic [31:0] core_out_hash  = 32'h0;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_hash;
    logic        d_match;
    logic [15:0] d_len;
    logic        d_err;

    int total = 0;
    int bad   = 0;

    hash_chain_driver #(.IV(IV), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_key(cfg_key), .exp_hash(exp_hash),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_key(core_key), .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_in_prev(core_in_prev), .core_busy(core_busy), .core_out_valid(core_out_valid),
        .core_out_hash(core_out_hash), .d_valid(d_valid), .d_ready(d_ready), .d_hash(d_hash),
        .d_match(d_match), .d_len(d_len), .d_err(d_err)
    );

    always #5 clk = ~clk;

    // The hash the behavioural core computes; the scoreboard folds it over each message.
    function automatic logic [31:0] hfn(input logic [31:0] k, input logic [31:0] d, input logic [31:0] p);
        logic [31:0] x;
        x = (p ^ d) * 32'h9E37_79B1;
        return {x[18:0], x[31:19]} ^ k ^ (d + 32'h1234_5678);
    endfunction

    // Behavioural core: answers two cycles after the request cycle when enabled.
    logic        core_en = 1'b1;
    logic        pipe1   = 1'b0;
    logic [31:0] hash_p1 = 32'h0;
    logic [31:0] req_d[$];
    logic [31:0] req_p[$];
    logic [31:0] req_k[$];

    always @(posedge clk) begin
        pipe1          <= ((core_in_valid & core_en) === 1'b1);
        hash_p1        <= hfn(core_key, core_in_data, core_in_prev);
        core_out_valid <= pipe1;
        core_out_hash  <= pipe1 ? hash_p1 : $urandom;
        if (core_in_valid === 1'b1) begin
            req_d.push_back(core_in_data);
            req_p.push_back(core_in_prev);
            req_k.push_back(core_key);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input logic [31:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(n < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'($urandom);
        #1;
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        while (d_valid !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("dvalid_wait", 32'(n < 100), 32'd1);
    endtask

    task automatic take(input logic [31:0] eh, input logic [15:0] el, input logic em,
                        input logic ee, input int dly);
        for (int i = 0; i <= dly; i++) begin
            chk("d_valid", 32'(d_valid), 32'd1);
            chk("d_hash", d_hash, eh);
            chk("d_len", 32'(d_len), 32'(el));
            chk("d_match", 32'(d_match), 32'(em));
            chk("d_err", 32'(d_err), 32'(ee));
            chk("done_sready", 32'(s_ready), 32'd0);
            if (i < dly) begin
                @(negedge clk); #1;
            end
        end
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
        #1;
        chk("after_take_dvalid", 32'(d_valid), 32'd0);
        chk("after_take_derr", 32'(d_err), 32'd0);
    endtask

    task automatic run_msg(input int n, input logic want_match, input int dly);
        logic [31:0] w[$];
        logic [31:0] key;
        logic [31:0] ch;
        logic [31:0] p;
        int          base;
        int          k;
        base = req_d.size();
        key  = $urandom;
        ch   = IV;
        for (int i = 0; i < n; i++) begin
            w.push_back($urandom);
            ch = hfn(key, w[i], ch);
        end
        cfg_key  = key;
        exp_hash = want_match ? ch : ~ch;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                core_busy = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk); #1;
                    chk("busy_sready", 32'(s_ready), 32'd0);
                end
                core_busy = 1'b0;
            end
            put_word(w[i], (i == n - 1));
            if (i == 0) begin
                cfg_key  = $urandom;
                exp_hash = $urandom;
            end
        end
        wait_dv(k);
        chk("req_count", 32'(req_d.size() - base), 32'(n));
        p = IV;
        for (int i = 0; i < n; i++) begin
            if (base + i < req_d.size()) begin
                chk("req_data", req_d[base + i], w[i]);
                chk("req_prev", req_p[base + i], p);
                chk("req_key", req_k[base + i], key);
            end
            p = hfn(key, w[i], p);
        end
        take(ch, 16'(n), want_match, 1'b0, dly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] key;
        logic [31:0] word;
        logic [31:0] sampled;
        logic [31:0] eh;
        int          base;
        int          n;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        core_busy = 1'b0; d_ready = 1'b0; cfg_key = '0; exp_hash = '0;

        // Values while reset is held.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_civ", 32'(core_in_valid), 32'd0);
        chk("rst_dvalid", 32'(d_valid), 32'd0);
        chk("rst_dmatch", 32'(d_match), 32'd0);
        chk("rst_derr", 32'(d_err), 32'd0);
        chk("rst_dlen", 32'(d_len), 32'd0);
        chk("rst_dhash", d_hash, 32'd0);
        chk("rst_prev", core_in_prev, IV);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word with exact cycle-by-cycle timing.
        key = $urandom;
        eh  = hfn(key, 32'h0000_0001, IV);
        cfg_key = key; exp_hash = eh;
        s_valid = 1'b1; s_data = 32'h0000_0001; s_last = 1'b1;
        #1;
        chk("t0_sready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0; s_data = $urandom; cfg_key = $urandom; exp_hash = $urandom;
        #1;
        chk("t1_civ", 32'(core_in_valid), 32'd1);
        chk("t1_data", core_in_data, 32'h0000_0001);
        chk("t1_prev", core_in_prev, IV);
        chk("t1_key", core_key, key);
        @(negedge clk); #1;
        chk("t2_civ", 32'(core_in_valid), 32'd0);
        chk("t2_dvalid", 32'(d_valid), 32'd0);
        @(negedge clk); #1;
        sampled = core_out_hash;
        chk("t3_key", core_key, key);
        chk("t3_dvalid", 32'(d_valid), 32'd0);
        @(negedge clk); #1;
        chk("t4_dvalid", 32'(d_valid), 32'd1);
        chk("t4_hash_sampled", d_hash, sampled);
        take(eh, 16'd1, 1'b1, 1'b0, 0);
        chk("idle_sready", 32'(s_ready), 32'd1);

        // Three-word messages, matching and mismatching expected digest.
        run_msg(3, 1'b1, 0);
        run_msg(3, 1'b0, 1);

        // Digest held under backpressure for five cycles.
        run_msg(2, 1'b1, 5);

        // Core busy in IDLE blocks acceptance.
        key  = $urandom;
        word = $urandom;
        eh   = hfn(key, word, IV);
        cfg_key = key; exp_hash = eh;
        core_busy = 1'b1; s_valid = 1'b1; s_data = word; s_last = 1'b1;
        repeat (4) begin
            #1;
            chk("busy_idle_sready", 32'(s_ready), 32'd0);
            chk("busy_idle_civ", 32'(core_in_valid), 32'd0);
            @(negedge clk);
        end
        core_busy = 1'b0;
        #1;
        chk("busy_drop_sready", 32'(s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("busy_civ", 32'(core_in_valid), 32'd1);
        chk("busy_data", core_in_data, word);
        wait_dv(n);
        take(eh, 16'd1, 1'b1, 1'b0, 0);

        // Timeout mid-message: abort, flush remaining words, error digest.
        core_en = 1'b0;
        base = req_d.size();
        cfg_key = $urandom; exp_hash = 32'h0;
        put_word($urandom, 1'b0);
        n = 0;
        while (s_ready !== 1'b1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("to_flush_cycles", 32'(n), 32'd9);
        chk("to_flush_dvalid", 32'(d_valid), 32'd0);
        put_word($urandom, 1'b0);
        put_word($urandom, 1'b0);
        put_word($urandom, 1'b1);
        wait_dv(n);
        chk("to_req_count", 32'(req_d.size() - base), 32'd1);
        take(32'h0, 16'd1, 1'b0, 1'b1, 1);

        // Timeout on a last word goes straight to the digest.
        put_word($urandom, 1'b1);
        wait_dv(n);
        chk("to_last_cycles", 32'(n), 32'd9);
        take(32'h0, 16'd1, 1'b0, 1'b1, 0);
        core_en = 1'b1;
        run_msg(2, 1'b1, 0);

        // Reset during WAIT of a two-word message.
        base = req_d.size();
        cfg_key = $urandom;
        put_word($urandom, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sready", 32'(s_ready), 32'd0);
        chk("mid_rst_civ", 32'(core_in_valid), 32'd0);
        chk("mid_rst_dvalid", 32'(d_valid), 32'd0);
        chk("mid_rst_dlen", 32'(d_len), 32'd0);
        chk("mid_rst_dhash", d_hash, 32'd0);
        chk("mid_rst_prev", core_in_prev, IV);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        repeat (6) begin
            chk("post_rst_dvalid", 32'(d_valid), 32'd0);
            chk("post_rst_civ", 32'(core_in_valid), 32'd0);
            @(negedge clk); #1;
        end
        chk("post_rst_reqs", 32'(req_d.size() - base), 32'd1);
        run_msg(1, 1'b1, 0);

        // Randomized messages.
        for (int m = 0; m < 12; m++) begin
            run_msg($urandom_range(1, 5), 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
